// File: rtl/sd_uart_tx_fifo.sv
// FIFO-buffered RS232 transmitter: configurable data bits, parity and stop bits.
// Optional line-break generator enabled by defining SD_UART_TX_BREAK_EN.
module sd_uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 20_000_000,
    parameter int unsigned UART_BPS   = 921_600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic [DATA_BITS-1:0]          pi_data,
    input  logic                          pi_valid,
`ifdef SD_UART_TX_BREAK_EN
    input  logic                          pi_break,
`endif
    output logic                          pi_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned BAUD_CNT_MAX = (CLK_FREQ + UART_BPS / 2) / UART_BPS;
    localparam int unsigned BAUD_W       = $clog2(BAUD_CNT_MAX + 1);
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);
    localparam int unsigned LW           = AW + 1;
    localparam int unsigned BIT_W        = 4;
    localparam int unsigned BREAK_BITS   = 13;
    localparam bit          PAR_EN       = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_MARK
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [LW-1:0]          level_nxt;
    logic                   push_c;
    logic                   pop_c;
    logic                   fifo_empty_c;
    logic [DATA_BITS-1:0]   head_c;
    logic                   par_c;

    logic [BAUD_W-1:0]      baud_cnt;
    logic                   baud_done_c;
    logic [BIT_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_q;
    logic                   tx_c;
    logic                   brk_pend;

    assign push_c       = pi_valid && pi_ready;
    assign fifo_empty_c = (fifo_level == LW'(0));
    assign baud_done_c  = (baud_cnt == BAUD_W'(BAUD_CNT_MAX - 1));
    assign head_c       = mem[rd_ptr];
    assign par_c        = (PARITY == 1) ? ~(^head_c) : (^head_c);
    assign level_nxt    = fifo_level + LW'(push_c) - LW'(pop_c);

    // A break request is latched until the line is free; pulses during a break merge into it.
`ifdef SD_UART_TX_BREAK_EN
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            brk_pend <= 1'b0;
        end else if (state_nxt == S_BREAK && state != S_BREAK) begin
            brk_pend <= 1'b0;
        end else if (pi_break && state != S_BREAK && state != S_MARK) begin
            brk_pend <= 1'b1;
        end
    end
`else
    assign brk_pend = 1'b0;
`endif

    // State register
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (brk_pend)           state_nxt = S_BREAK;
                else if (!fifo_empty_c) state_nxt = S_START;
            end
            S_START: begin
                if (baud_done_c) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (baud_done_c && bit_cnt == BIT_W'(DATA_BITS - 1))
                    state_nxt = PAR_EN ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (baud_done_c) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (baud_done_c && bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                    if (brk_pend)           state_nxt = S_BREAK;
                    else if (!fifo_empty_c) state_nxt = S_START;
                    else                    state_nxt = S_IDLE;
                end
            end
            S_BREAK: begin
                if (baud_done_c && bit_cnt == BIT_W'(BREAK_BITS - 1)) state_nxt = S_MARK;
            end
            S_MARK: begin
                if (baud_done_c) state_nxt = fifo_empty_c ? S_IDLE : S_START;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode; every entry into START consumes the FIFO head
    always_comb begin
        tx_c  = 1'b1;
        pop_c = (state_nxt == S_START) && (state != S_START);
        case (state)
            S_START:  tx_c = 1'b0;
            S_DATA:   tx_c = shift_q[0];
            S_PARITY: tx_c = par_q;
            S_BREAK:  tx_c = 1'b0;
            default:  tx_c = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (push_c) mem[wr_ptr] <= pi_data;
    end

    // Datapath, counters and registered outputs; tx trails the state by one clock
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            pi_ready   <= 1'b1;
            busy       <= 1'b0;
            tx         <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c) begin
                rd_ptr  <= rd_ptr + AW'(1);
                shift_q <= head_c;
                par_q   <= par_c;
            end else if (state == S_DATA && baud_done_c) begin
                shift_q <= shift_q >> 1;
            end

            if (state == S_IDLE || state_nxt != state || baud_done_c) baud_cnt <= '0;
            else                                                      baud_cnt <= baud_cnt + BAUD_W'(1);

            if (state_nxt != state) bit_cnt <= '0;
            else if (baud_done_c)   bit_cnt <= bit_cnt + BIT_W'(1);

            fifo_level <= level_nxt;
            pi_ready   <= (level_nxt != LW'(FIFO_DEPTH));
            busy       <= (state != S_IDLE) || (state_nxt != S_IDLE) || (level_nxt != LW'(0));
            tx         <= tx_c;
        end
    end

endmodule

// File: tb/tb_sd_uart_tx_fifo.sv
// Scoreboard bench for sd_uart_tx_fifo: four parameter sets, frame-decoding monitors.
module tb_sd_uart_tx_fifo;

    localparam int BIT_CLKS = 22;

    typedef struct {
        int         idx;
        logic [8:0] data;
        logic       par;
        bit         b2b;
    } exp_t;

    logic       clk = 1'b0;
    logic [3:0] rstv = 4'b0000;
    logic [3:0] valv = 4'b0000;
    logic [3:0] readyv, txv, busyv;
    logic [7:0] dat0 = '0, dat1 = '0, dat2 = '0;
    logic [6:0] dat3 = '0;
    logic [4:0] lvl0, lvl1, lvl2;
    logic [2:0] lvl3;
    logic       brk0 = 1'b0;
    bit   [3:0] mon_en = 4'b1111;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   last_fall [4];
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sd_uart_tx_fifo u0 (
        .sys_clk(clk), .sys_rst_n(rstv[0]), .pi_data(dat0), .pi_valid(valv[0]),
`ifdef SD_UART_TX_BREAK_EN
        .pi_break(brk0),
`endif
        .pi_ready(readyv[0]), .tx(txv[0]), .busy(busyv[0]), .fifo_level(lvl0));

    sd_uart_tx_fifo #(.PARITY(2)) u1 (
        .sys_clk(clk), .sys_rst_n(rstv[1]), .pi_data(dat1), .pi_valid(valv[1]),
`ifdef SD_UART_TX_BREAK_EN
        .pi_break(1'b0),
`endif
        .pi_ready(readyv[1]), .tx(txv[1]), .busy(busyv[1]), .fifo_level(lvl1));

    sd_uart_tx_fifo #(.PARITY(1)) u2 (
        .sys_clk(clk), .sys_rst_n(rstv[2]), .pi_data(dat2), .pi_valid(valv[2]),
`ifdef SD_UART_TX_BREAK_EN
        .pi_break(1'b0),
`endif
        .pi_ready(readyv[2]), .tx(txv[2]), .busy(busyv[2]), .fifo_level(lvl2));

    sd_uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .sys_clk(clk), .sys_rst_n(rstv[3]), .pi_data(dat3), .pi_valid(valv[3]),
`ifdef SD_UART_TX_BREAK_EN
        .pi_break(1'b0),
`endif
        .pi_ready(readyv[3]), .tx(txv[3]), .busy(busyv[3]), .fifo_level(lvl3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) tick();
    endtask

    function automatic int find_q(input int idx);
        for (int i = 0; i < q.size(); i++) if (q[i].idx == idx) return i;
        return -1;
    endfunction

    // Drives one accepted word; optionally records the frame the monitor must see.
    task automatic push(input int idx, input logic [8:0] d, input logic par, input bit b2b,
                        input bit expect_frame);
        case (idx)
            0: dat0 = d[7:0];
            1: dat1 = d[7:0];
            2: dat2 = d[7:0];
            default: dat3 = d[6:0];
        endcase
        valv[idx] = 1'b1;
        chk($sformatf("u%0d_ready_at_push", idx), 32'(readyv[idx]), 32'd1);
        tick();
        valv[idx] = 1'b0;
        if (expect_frame) q.push_back('{idx, d, par, b2b});
    endtask

    task automatic wait_idle(input int idx, input int budget);
        int n = 0;
        while ((busyv[idx] || find_q(idx) >= 0) && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("u%0d_drain", idx), 32'(n < budget), 32'd1);
    endtask

    // Decodes frames from one tx line, sampling mid-bit, and pops the scoreboard.
    task automatic mon(input int idx, input int nbits, input bit par_en, input int nstop);
        int flen = (1 + nbits + (par_en ? 1 : 0) + nstop) * BIT_CLKS;
        forever begin
            @(negedge clk);
            if (mon_en[idx] && txv[idx] == 1'b0) begin
                int         fall;
                int         k;
                int         stop_ok;
                logic [8:0] d;
                logic       p;
                fall    = cyc;
                d       = '0;
                p       = 1'b0;
                stop_ok = 1;
                repeat (BIT_CLKS / 2) @(negedge clk);
                chk($sformatf("u%0d_start_bit", idx), 32'(txv[idx]), 32'd0);
                for (int i = 0; i < nbits; i++) begin
                    repeat (BIT_CLKS) @(negedge clk);
                    d[i] = txv[idx];
                end
                if (par_en) begin
                    repeat (BIT_CLKS) @(negedge clk);
                    p = txv[idx];
                end
                for (int s = 0; s < nstop; s++) begin
                    repeat (BIT_CLKS) @(negedge clk);
                    if (txv[idx] !== 1'b1) stop_ok = 0;
                end
                k = find_q(idx);
                chk($sformatf("u%0d_frame_expected", idx), 32'(k >= 0), 32'd1);
                if (k >= 0) begin
                    chk($sformatf("u%0d_data", idx), 32'(d), 32'(q[k].data));
                    if (par_en) chk($sformatf("u%0d_parity", idx), 32'(p), 32'(q[k].par));
                    chk($sformatf("u%0d_stop_bits", idx), 32'(stop_ok), 32'd1);
                    if (q[k].b2b)
                        chk($sformatf("u%0d_b2b_gap", idx), 32'(fall - last_fall[idx]), 32'(flen));
                    q.delete(k);
                end
                last_fall[idx] = fall;
            end
        end
    endtask

    initial begin
        fork
            mon(0, 8, 1'b0, 1);
            mon(1, 8, 1'b1, 1);
            mon(2, 8, 1'b1, 1);
            mon(3, 7, 1'b0, 2);
        join_none
    end

    initial begin
        #300_000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1);
    end

    initial begin
        int c0;
        int k;
        int guard;
        int maxl;
        int zeros;
        int busy_hi;
        bit r;

        // Reset state
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("u%0d_rst_tx", i),    32'(txv[i]),    32'd1);
            chk($sformatf("u%0d_rst_busy", i),  32'(busyv[i]),  32'd0);
            chk($sformatf("u%0d_rst_ready", i), 32'(readyv[i]), 32'd1);
        end
        chk("u0_rst_level", 32'(lvl0), 32'd0);
        chk("u1_rst_level", 32'(lvl1), 32'd0);
        chk("u2_rst_level", 32'(lvl2), 32'd0);
        chk("u3_rst_level", 32'(lvl3), 32'd0);
        rstv = 4'b1111;
        tick();

        // 8N1 0x55: start at E+2, 220-clock frame
        push(0, 9'h055, 1'b0, 1'b0, 1'b1);
        c0 = cyc;
        wait_to(c0 + 1);   chk("u0_latency_e1_tx", 32'(txv[0]), 32'd1);
        wait_to(c0 + 2);   chk("u0_latency_e2_tx", 32'(txv[0]), 32'd0);
        wait_to(c0 + 221); chk("u0_busy_e221", 32'(busyv[0]), 32'd1);
        wait_to(c0 + 222); chk("u0_busy_e222", 32'(busyv[0]), 32'd0);
        wait_idle(0, 400);

        // Even parity 0xA5: parity 0, 242-clock frame
        push(1, 9'h0A5, 1'b0, 1'b0, 1'b1);
        c0 = cyc;
        wait_to(c0 + 243); chk("u1_busy_e243", 32'(busyv[1]), 32'd1);
        wait_to(c0 + 244); chk("u1_busy_e244", 32'(busyv[1]), 32'd0);
        wait_idle(1, 400);

        // Odd parity 0x01 -> 0, 0x03 -> 1, sent back to back
        push(2, 9'h001, 1'b0, 1'b0, 1'b1);
        push(2, 9'h003, 1'b1, 1'b1, 1'b1);
        wait_idle(2, 800);

        // 7 data bits, 2 stop bits, 0x7F: 220-clock frame
        push(3, 9'h07F, 1'b0, 1'b0, 1'b1);
        c0 = cyc;
        wait_to(c0 + 221); chk("u3_busy_e221", 32'(busyv[3]), 32'd1);
        wait_to(c0 + 222); chk("u3_busy_e222", 32'(busyv[3]), 32'd0);
        wait_idle(3, 400);

        // Depth-4 FIFO streamed with pi_valid held high
        k = 0;
        guard = 0;
        maxl = 0;
        while (k < 8 && guard < 4000) begin
            dat3 = 7'(k);
            valv[3] = 1'b1;
            r = readyv[3];
            tick();
            guard++;
            if (r) begin
                q.push_back('{3, 9'(k), 1'b0, k > 0});
                k++;
            end
            chk("u3_ready_vs_full", 32'(readyv[3]), 32'(lvl3 != 3'd4));
            if (int'(lvl3) > maxl) maxl = int'(lvl3);
        end
        valv[3] = 1'b0;
        chk("u3_stream_accepted", 32'(k), 32'd8);
        chk("u3_max_level", 32'(maxl), 32'd4);
        wait_idle(3, 3000);

`ifdef SD_UART_TX_BREAK_EN
        // Break mid-frame with 0x41 queued: frame completes, 286 low, 22 high, then 0x41
        push(0, 9'h030, 1'b0, 1'b0, 1'b1);
        c0 = cyc;
        push(0, 9'h041, 1'b0, 1'b0, 1'b0);
        wait_to(c0 + 50);
        brk0 = 1'b1;
        tick();
        brk0 = 1'b0;
        wait_to(c0 + 215); mon_en[0] = 1'b0;
        wait_to(c0 + 221); chk("u0_brk_last_stop", 32'(txv[0]), 32'd1);
        wait_to(c0 + 222); chk("u0_brk_begin", 32'(txv[0]), 32'd0);
        wait_to(c0 + 300);
        brk0 = 1'b1;
        tick();
        brk0 = 1'b0;
        wait_to(c0 + 400); chk("u0_brk_mid_tx", 32'(txv[0]), 32'd0);
        chk("u0_brk_mid_busy", 32'(busyv[0]), 32'd1);
        wait_to(c0 + 507); chk("u0_brk_end_low", 32'(txv[0]), 32'd0);
        wait_to(c0 + 508); chk("u0_brk_mark", 32'(txv[0]), 32'd1);
        q.push_back('{0, 9'h041, 1'b0, 1'b0});
        mon_en[0] = 1'b1;
        wait_to(c0 + 529); chk("u0_brk_mark_end", 32'(txv[0]), 32'd1);
        wait_to(c0 + 530); chk("u0_post_brk_start", 32'(txv[0]), 32'd0);
        wait_idle(0, 600);
`endif

        // Reset during data bit 3 of 0x00 with three more words queued
        mon_en[0] = 1'b0;
        push(0, 9'h000, 1'b0, 1'b0, 1'b0);
        c0 = cyc;
        push(0, 9'h011, 1'b0, 1'b0, 1'b0);
        push(0, 9'h022, 1'b0, 1'b0, 1'b0);
        push(0, 9'h033, 1'b0, 1'b0, 1'b0);
        wait_to(c0 + 99);
        chk("u0_pre_rst_tx", 32'(txv[0]), 32'd0);
        chk("u0_pre_rst_level", 32'(lvl0), 32'd3);
        rstv[0] = 1'b0;
        tick();
        chk("u0_rst_mid_tx", 32'(txv[0]), 32'd1);
        chk("u0_rst_mid_level", 32'(lvl0), 32'd0);
        chk("u0_rst_mid_busy", 32'(busyv[0]), 32'd0);
        chk("u0_rst_mid_ready", 32'(readyv[0]), 32'd1);
        rstv[0] = 1'b1;
        zeros = 0;
        busy_hi = 0;
        repeat (600) begin
            tick();
            if (txv[0] !== 1'b1) zeros++;
            if (busyv[0] !== 1'b0) busy_hi++;
        end
        chk("u0_no_frame_after_rst", 32'(zeros), 32'd0);
        chk("u0_idle_after_rst", 32'(busy_hi), 32'd0);

        for (int i = 0; i < 4; i++)
            chk($sformatf("u%0d_scoreboard_empty", i), 32'(find_q(i) < 0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
